// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: depth helper, pointer type and Gray conversions
// (the conversions are shared with the dual-clock FIFO).
package fifo_pkg;

    localparam int ADDR_SIZE  = 4;
    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 1 << ADDR_SIZE;

    typedef logic [ADDR_SIZE:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[ADDR_SIZE] = g[ADDR_SIZE];
        for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer handshake and status bundle of the single-clock FIFO.
interface sync_fifo_ctrl_if #(
    parameter int addr_size  = 4,
    parameter int data_width = 8
);
    logic                  winc;
    logic [data_width-1:0] wdata;
    logic                  rinc;
    logic [data_width-1:0] rdata;
    logic                  wfull;
    logic                  rempty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [addr_size:0]    count;
    logic [addr_size-1:0]  waddr;
    logic [addr_size-1:0]  raddr;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output winc, wdata, rinc,
        input  rdata, wfull, rempty, almost_full, almost_empty,
               count, waddr, raddr, overflow, underflow
    );

    modport slave (
        input  winc, wdata, rinc,
        output rdata, wfull, rempty, almost_full, almost_empty,
               count, waddr, raddr, overflow, underflow
    );
endinterface

// File: rtl/fifo_mem.sv
// Dual-port register array: synchronous write, asynchronous read, no reset.
module fifo_mem #(
    parameter int addr_size  = 4,
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_size-1:0]  waddr,
    input  logic [data_width-1:0] wdata,
    input  logic [addr_size-1:0]  raddr,
    output logic [data_width-1:0] rdata
);
    localparam int depth = 1 << addr_size;

    logic [data_width-1:0] mem_q [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: binary pointers, registered flags/count, overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through read data.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int addr_size  = ADDR_SIZE,
    parameter int data_width = DATA_WIDTH,
    parameter int af_level   = 14,
    parameter int ae_level   = 2
) (
    input  logic           clk,
    input  logic           rst,
    sync_fifo_ctrl_if.slave bus
);
    localparam logic [addr_size:0] af_thr = af_level[addr_size:0];
    localparam logic [addr_size:0] ae_thr = ae_level[addr_size:0];

    logic [addr_size:0]    wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    logic                  wfull_q, wfull_d, rempty_q, rempty_d;
    logic                  af_q, af_d, ae_q, ae_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  wr_acc, rd_acc;
    logic [data_width-1:0] mem_rdata;

    // Accepts use the flags registered before the edge.
    always_comb begin
        wr_acc   = bus.winc & ~wfull_q;
        rd_acc   = bus.rinc & ~rempty_q;
        wptr_d   = wptr_q + {{addr_size{1'b0}}, wr_acc};
        rptr_d   = rptr_q + {{addr_size{1'b0}}, rd_acc};
        wfull_d  = (wptr_d == {~rptr_d[addr_size], rptr_d[addr_size-1:0]});
        rempty_d = (wptr_d == rptr_d);
        count_d  = wptr_d - rptr_d;
        af_d     = (count_d >= af_thr);
        ae_d     = (count_d <= ae_thr);
        ovf_d    = bus.winc & wfull_q;
        unf_d    = bus.rinc & rempty_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            wfull_q  <= wfull_d;
            rempty_q <= rempty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_mem #(
        .addr_size  (addr_size),
        .data_width (data_width)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc & ~rst),
        .waddr (wptr_q[addr_size-1:0]),
        .wdata (bus.wdata),
        .raddr (rptr_q[addr_size-1:0]),
        .rdata (mem_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is visible whenever the FIFO is non-empty.
    assign bus.rdata = mem_rdata;
`else
    logic [data_width-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rd_acc ? mem_rdata : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign bus.rdata = rdata_q;
`endif

    assign bus.wfull        = wfull_q;
    assign bus.rempty       = rempty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = count_q;
    assign bus.waddr        = wptr_q[addr_size-1:0];
    assign bus.raddr        = rptr_q[addr_size-1:0];
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule
